// File: rtl/weight_loader_if.sv
// Host/memory-side signal bundle for weight_loader: start/abort control, byte stream,
// weight-memory write port and status. The loader uses the slave modport.
interface weight_loader_if #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 6
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  abort;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    output start, start_addr, length, abort, in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata, busy, done, error, checksum
  );

  modport slave (
    input  start, start_addr, length, abort, in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata, busy, done, error, checksum
  );
endinterface

// File: rtl/weight_loader.sv
// Turns a valid/ready byte stream into sequential, wrapping write strobes for the weight store.
// Optional running byte checksum enabled by defining WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 6
) (
  input  logic           clk,
  input  logic           reset,
  weight_loader_if.slave wl
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [LEN_WIDTH-1:0]  DEPTH_L   = LEN_WIDTH'(DEPTH);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  in_ready_q, mem_we_q, busy_q, done_q, error_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  start_bad, start_ok, start_err, wr_ok;

  always_comb begin
    addr_d    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);
    start_bad = (wl.start_addr >= DEPTH_A) || (wl.length > DEPTH_L);
    // abort has priority over start in IDLE and over a handshake in LOAD
    start_ok  = (state_q == IDLE) && wl.start && !wl.abort && !start_bad;
    start_err = (state_q == IDLE) && wl.start && !wl.abort && start_bad;
    wr_ok     = wl.in_valid && in_ready_q && !wl.abort;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_err) begin
            error_q <= 1'b1;
          end else if (start_ok) begin
            busy_q <= 1'b1;
            if (wl.length == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= LOAD;
              addr_q     <= wl.start_addr;
              rem_q      <= wl.length;
              in_ready_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (wl.abort) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
          end else if (wr_ok) begin
            mem_we_q <= 1'b1;
            waddr_q  <= addr_q;
            wdata_q  <= wl.in_data;
            addr_q   <= addr_d;
            rem_q    <= rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
              state_q    <= DONE;
              in_ready_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      csum_q <= '0;
    end else if (wr_ok) begin
      csum_q <= csum_q + wl.in_data;
    end
  end

  assign wl.checksum = csum_q;
`else
  assign wl.checksum = '0;
`endif

  assign wl.in_ready  = in_ready_q;
  assign wl.mem_we    = mem_we_q;
  assign wl.mem_waddr = waddr_q;
  assign wl.mem_wdata = wdata_q;
  assign wl.busy      = busy_q;
  assign wl.done      = done_q;
  assign wl.error     = error_q;

endmodule
